// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: op encodings and sequencer states.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_serial_seq_if.sv
// Request/result bundle between the operand stage and the bit-serial ALU sequencer.
interface alu_serial_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             ovf;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, zero, ovf
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, zero, ovf
  );
endinterface

// File: rtl/alu_slice.sv
// One-bit ALU slice: AND/OR/ADD/SUB on single bits; SUB inverts i1 and relies on cin=1 at the LSB.
module alu_slice
  import alu_pkg::*;
(
  input  logic       i0_i,
  input  logic       i1_i,
  input  logic       cin_i,
  input  logic [1:0] op_i,
  output logic       o_o,
  output logic       cout_o
);

  logic b_eff;

  always_comb begin
    b_eff  = op_i[0] ? ~i1_i : i1_i;
    o_o    = 1'b0;
    cout_o = 1'b0;
    unique case (op_i)
      OP_AND: o_o = i0_i & i1_i;
      OP_OR:  o_o = i0_i | i1_i;
      OP_ADD, OP_SUB: begin
        o_o    = i0_i ^ b_eff ^ cin_i;
        cout_o = (i0_i & b_eff) | (cin_i & (i0_i ^ b_eff));
      end
      default: o_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial operand sequencer around a single alu_slice; one op per WIDTH+1 cycles.
// Optional signed-overflow flag built only when ALU_SERIAL_OVF_EN is defined.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_serial_seq_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       op_q, op_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             accept, last;
  logic             s_o, s_cout;

  alu_slice u_slice (
    .i0_i   (a_sh_q[0]),
    .i1_i   (b_sh_q[0]),
    .cin_i  (carry_q),
    .op_i   (op_q),
    .o_o    (s_o),
    .cout_o (s_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    result_d = result_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));
    last     = (state_q == RUN) && (cnt_q == CntW'(WIDTH - 1));

    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_sh_d  = bus.a;
      b_sh_d  = bus.b;
      op_d    = bus.op;
      cnt_d   = '0;
      carry_d = (bus.op == OP_SUB);
    end else if (state_q == RUN) begin
      result_d = {s_o, result_q[WIDTH-1:1]};
      a_sh_d   = a_sh_q >> 1;
      b_sh_d   = b_sh_q >> 1;
      // Logic ops keep carry at its accept value of 0.
      if (op_q[1]) carry_d = s_cout;
      cnt_d = cnt_q + CntW'(1);
      if (last) zero_d = ~|result_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      op_q     <= OP_AND;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      result_q <= result_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

`ifdef ALU_SERIAL_OVF_EN
  // Carry into the MSB slice, captured on the final RUN edge.
  logic cin_msb_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cin_msb_q <= 1'b0;
    else if (last) cin_msb_q <= carry_q;
  end

  assign bus.ovf = op_q[1] & (cin_msb_q ^ carry_q);
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.cout   = carry_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed self-checking bench for alu_serial_seq at WIDTH=8.
module tb_alu_serial_seq;
  import alu_pkg::*;

  localparam int unsigned W = 8;
`ifdef ALU_SERIAL_OVF_EN
  localparam logic OvfOn = 1'b1;
`else
  localparam logic OvfOn = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  alu_serial_seq_if #(.WIDTH(W)) bus_if ();

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start an op at a negedge (cycle 0); return the cycle index where done was seen.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int cycles);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op    = op;
    bus_if.a     = a;
    bus_if.b     = b;
    @(negedge clk);
    cycles       = 1;
    bus_if.start = 1'b0;
    while (!bus_if.done && cycles < 30) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset_n      = 1'b0;
    bus_if.start = 1'b0;
    bus_if.op    = OP_AND;
    bus_if.a     = '0;
    bus_if.b     = '0;
    #1;
    checks++;
    if ({bus_if.busy, bus_if.done, bus_if.cout, bus_if.zero, bus_if.ovf} !== 5'b0 ||
        bus_if.result !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags got busy=%b done=%b cout=%b zero=%b ovf=%b result=%h want all 0",
               bus_if.busy, bus_if.done, bus_if.cout, bus_if.zero, bus_if.ovf, bus_if.result);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b done=%b want 0 0", bus_if.busy, bus_if.done);
    end
  endtask

  task automatic test_ops;
    logic [1:0]   v_op  [7] = '{OP_ADD, OP_SUB, OP_SUB, OP_SUB, OP_AND, OP_OR, OP_ADD};
    logic [W-1:0] v_a   [7] = '{8'h7F, 8'h07, 8'h05, 8'h55, 8'hF0, 8'hF0, 8'h3C};
    logic [W-1:0] v_b   [7] = '{8'h01, 8'h05, 8'h07, 8'h55, 8'h3C, 8'h0C, 8'h0F};
    logic [W-1:0] v_res [7] = '{8'h80, 8'h02, 8'hFE, 8'h00, 8'h30, 8'hFC, 8'h4B};
    logic         v_co  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic         v_z   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic         v_ov  [7] = '{OvfOn, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int cyc;
    for (int i = 0; i < 7; i++) begin
      run_op(v_op[i], v_a[i], v_b[i], cyc);
      checks++;
      if (cyc !== 9) begin
        errors++;
        $display("FAIL op%0d_latency got %0d want 9", i, cyc);
      end
      checks++;
      if (bus_if.result !== v_res[i] || bus_if.cout !== v_co[i] || bus_if.zero !== v_z[i] ||
          bus_if.ovf !== v_ov[i]) begin
        errors++;
        $display("FAIL op%0d_result got res=%h cout=%b zero=%b ovf=%b want res=%h cout=%b zero=%b ovf=%b",
                 i, bus_if.result, bus_if.cout, bus_if.zero, bus_if.ovf,
                 v_res[i], v_co[i], v_z[i], v_ov[i]);
      end
      @(negedge clk);
      checks++;
      if (bus_if.done !== 1'b0 || bus_if.result !== v_res[i] || bus_if.cout !== v_co[i]) begin
        errors++;
        $display("FAIL op%0d_hold got done=%b res=%h cout=%b want done=0 res=%h cout=%b",
                 i, bus_if.done, bus_if.result, bus_if.cout, v_res[i], v_co[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op    = OP_ADD;
    bus_if.a     = 8'h01;
    bus_if.b     = 8'h01;
    @(negedge clk);
    cyc          = 1;
    bus_if.start = 1'b0;
    checks++;
    if (bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy got %b want 1", bus_if.busy);
    end
    repeat (2) begin
      @(negedge clk);
      cyc++;
    end
    // Request during RUN must be dropped.
    bus_if.start = 1'b1;
    bus_if.op    = OP_OR;
    bus_if.a     = 8'hAA;
    bus_if.b     = 8'h55;
    @(negedge clk);
    cyc++;
    bus_if.start = 1'b0;
    while (!bus_if.done && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== 9 || bus_if.result !== 8'h02 || bus_if.cout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ignore got cyc=%0d res=%h cout=%b want cyc=9 res=02 cout=0",
               cyc, bus_if.result, bus_if.cout);
    end
    // Accept in the done cycle.
    bus_if.start = 1'b1;
    bus_if.op    = OP_ADD;
    bus_if.a     = 8'hFF;
    bus_if.b     = 8'h01;
    @(negedge clk);
    cyc          = 1;
    bus_if.start = 1'b0;
    checks++;
    if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart got busy=%b done=%b want 1 0", bus_if.busy, bus_if.done);
    end
    while (!bus_if.done && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== 9 || bus_if.result !== 8'h00 || bus_if.cout !== 1'b1 || bus_if.zero !== 1'b1 ||
        bus_if.ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got cyc=%0d res=%h cout=%b zero=%b ovf=%b want 9 00 1 1 0",
               cyc, bus_if.result, bus_if.cout, bus_if.zero, bus_if.ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op    = OP_SUB;
    bus_if.a     = 8'hFF;
    bus_if.b     = 8'h00;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus_if.busy !== 1'b1 || bus_if.result !== 8'hE0 || bus_if.cout !== 1'b1) begin
      errors++;
      $display("FAIL midrun_state got busy=%b res=%h cout=%b want 1 e0 1",
               bus_if.busy, bus_if.result, bus_if.cout);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus_if.busy, bus_if.done, bus_if.cout, bus_if.zero, bus_if.ovf} !== 5'b0 ||
        bus_if.result !== 8'h00) begin
      errors++;
      $display("FAIL midrun_reset got busy=%b done=%b cout=%b zero=%b ovf=%b res=%h want all 0",
               bus_if.busy, bus_if.done, bus_if.cout, bus_if.zero, bus_if.ovf, bus_if.result);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_idle got busy=%b done=%b want 0 0", bus_if.busy, bus_if.done);
    end
    run_op(OP_SUB, 8'h07, 8'h05, cyc);
    checks++;
    if (cyc !== 9 || bus_if.result !== 8'h02 || bus_if.cout !== 1'b1 || bus_if.zero !== 1'b0) begin
      errors++;
      $display("FAIL midrun_after got cyc=%0d res=%h cout=%b zero=%b want 9 02 1 0",
               cyc, bus_if.result, bus_if.cout, bus_if.zero);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ops();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
